// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: shared definitions for the transmitter scheduler.
// FSM state encoding, transmitter state codes and watchdog limits
// (the limits are used only when TX_SCHED_TIMEOUT_EN is defined).
package tx_sched_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LAUNCH     = 3'd1;
    localparam logic [2:0] ST_WAIT_START = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE  = 3'd3;
    localparam logic [2:0] ST_GAP        = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_LAUNCH     = ST_LAUNCH,
        S_WAIT_START = ST_WAIT_START,
        S_WAIT_DONE  = ST_WAIT_DONE,
        S_GAP        = ST_GAP
    } state_t;

    localparam logic [1:0] TX_IDLE  = 2'b00;
    localparam logic [1:0] TX_START = 2'b01;
    localparam logic [1:0] TX_DATA  = 2'b10;
    localparam logic [1:0] TX_STOP  = 2'b11;

    localparam int TIMEOUT_START = 4;
    localparam int TIMEOUT_DONE  = 16;
    localparam int WDOG_W        = 5;

endpackage

// File: rtl/tx_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Returns the first set request
// bit at or after ptr, wrapping modulo N_REQ. The pointer itself lives in
// the caller.
module rr_arbiter
    import tx_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr) + k) % N_REQ);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/tx_sched.sv
// tx_sched: round-robin scheduler sharing one serial byte transmitter among
// N_REQ requesters. Optional watchdog enabled by TX_SCHED_TIMEOUT_EN.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | wait for a request while the transmitter is idle
// LAUNCH     | tx_send high for this single cycle
// WAIT_START | wait for the transmitter to leave idle
// WAIT_DONE  | frame in flight; wait for the transmitter to return idle
// GAP        | ack pulse; guarantees tx_send low before the next launch
module tx_sched
    import tx_sched_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic                      tx_send,
    output logic [DATA_W-1:0]         tx_data,
    input  logic [1:0]                tx_state,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      err
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  ptr_next;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [DATA_W-1:0] data_q;

    // tx_data is the latched byte itself; it only changes on a new grant.
    assign tx_data  = data_q;
    assign ptr_next = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

`ifdef TX_SCHED_TIMEOUT_EN
    logic [WDOG_W-1:0] wdog;
    logic              err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            data_q   <= '0;
            ack      <= '0;
            tx_send  <= 1'b0;
            busy     <= 1'b0;
            grant_id <= '0;
`ifdef TX_SCHED_TIMEOUT_EN
            wdog     <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            ack     <= '0;
            tx_send <= 1'b0;
`ifdef TX_SCHED_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    // A frame left over from before reset must finish first.
                    if (pick_valid && tx_state == TX_IDLE) begin
                        grant_id <= pick_idx;
                        data_q   <= req_data[pick_idx*DATA_W +: DATA_W];
                        tx_send  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT_START;
`ifdef TX_SCHED_TIMEOUT_EN
                    wdog  <= WDOG_W'(TIMEOUT_START - 1);
`endif
                end
                S_WAIT_START: begin
                    if (tx_state != TX_IDLE) begin
                        state <= S_WAIT_DONE;
`ifdef TX_SCHED_TIMEOUT_EN
                        wdog  <= WDOG_W'(TIMEOUT_DONE - 1);
                    end else if (wdog == '0) begin
                        err_q  <= 1'b1;
                        rr_ptr <= ptr_next;
                        state  <= S_GAP;
                    end else begin
                        wdog <= wdog - 1'b1;
`endif
                    end
                end
                S_WAIT_DONE: begin
                    if (tx_state == TX_IDLE) begin
                        ack    <= N_REQ'(1) << grant_id;
                        rr_ptr <= ptr_next;
                        state  <= S_GAP;
`ifdef TX_SCHED_TIMEOUT_EN
                    end else if (wdog == '0) begin
                        err_q  <= 1'b1;
                        rr_ptr <= ptr_next;
                        state  <= S_GAP;
                    end else begin
                        wdog <= wdog - 1'b1;
`endif
                    end
                end
                S_GAP: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_sched.sv
// tb_tx_sched: self-checking bench for tx_sched with a behavioural
// transmitter and a cycle-level reference model of the scheduling rules.
// Define TX_SCHED_TIMEOUT_EN for both bench and RTL to cover the watchdog.
module tb_tx_sched;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   ack;
    logic           tx_send;
    logic [W-1:0]   tx_data;
    logic [1:0]     tx_state;
    logic           busy;
    logic [1:0]     grant_id;
    logic           err;

    always #5 clk = ~clk;

    tx_sched #(.N_REQ(N), .DATA_W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .tx_state (tx_state),
        .busy     (busy),
        .grant_id (grant_id),
        .err      (err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // values present at the coming clock edge
    logic [N-1:0]   s_req;
    logic [N*W-1:0] s_data;
    logic [1:0]     s_txs;
    logic           s_rst;
    logic           s_send;

    // transmitter environment
    int tx_cnt = 0;
    bit stuck  = 1'b0;

    // reference model
    int        m_phase;  // 0 idle,1 launch,2 wait start,3 frame,4 gap
    int        m_ptr;
    int        m_grant;
    int        m_wcnt;
    logic [7:0] m_data;
    logic [3:0] m_ack;
    bit        m_send;
    bit        m_err;

    // observation logs
    bit         last_send;
    logic [3:0] last_ack;
    bit         last_err;
    int         send_cyc[$];
    int         send_gid[$];
    int         send_dat[$];
    int         ack_cyc[$];
    int         err_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_grant = 0; m_wcnt = 0;
        m_data = 8'h00; m_ack = 4'h0; m_send = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_edge();
        bit found;
        m_ack  = 4'h0;
        m_send = 1'b0;
        m_err  = 1'b0;
        case (m_phase)
            0: if (s_req != 0 && s_txs == 2'b00) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found && ((s_req >> ((m_ptr + k) % N)) & 1) != 0) begin
                        found   = 1'b1;
                        m_grant = (m_ptr + k) % N;
                    end
                end
                m_data  = s_data[m_grant*8 +: 8];
                m_send  = 1'b1;
                m_phase = 1;
            end
            1: begin m_phase = 2; m_wcnt = 0; end
            2: if (s_txs != 2'b00) begin
                m_phase = 3; m_wcnt = 0;
            end else begin
                m_wcnt++;
`ifdef TX_SCHED_TIMEOUT_EN
                if (m_wcnt == 4) begin
                    m_err = 1'b1; m_ptr = (m_grant + 1) % N; m_phase = 4;
                end
`endif
            end
            3: if (s_txs == 2'b00) begin
                m_ack   = 4'(1 << m_grant);
                m_ptr   = (m_grant + 1) % N;
                m_phase = 4;
            end else begin
                m_wcnt++;
`ifdef TX_SCHED_TIMEOUT_EN
                if (m_wcnt == 16) begin
                    m_err = 1'b1; m_ptr = (m_grant + 1) % N; m_phase = 4;
                end
`endif
            end
            default: m_phase = 0;
        endcase
    endtask

    // One clock: sample inputs, advance model, compare, advance transmitter.
    task automatic step();
        @(negedge clk);
        s_req = req; s_data = req_data; s_txs = tx_state; s_rst = rst; s_send = tx_send;
        @(posedge clk);
        #1;
        cyc++;
        if (!s_rst) model_reset();
        else        model_edge();
        check("send",  32'(tx_send),  32'(m_send));
        check("data",  32'(tx_data),  32'(m_data));
        check("ack",   32'(ack),      32'(m_ack));
        check("busy",  32'(busy),     32'(m_phase != 0));
        check("grant", 32'(grant_id), 32'(m_grant));
        check("err",   32'(err),      32'(m_err));
        last_send = tx_send;
        last_ack  = ack;
        last_err  = err;
        if (tx_send) begin
            send_cyc.push_back(cyc);
            send_gid.push_back(int'(grant_id));
            send_dat.push_back(int'(tx_data));
        end
        if (ack != 0) ack_cyc.push_back(cyc);
        if (err) err_cyc.push_back(cyc);
        // transmitter: 1 start, 8 data, 1 stop after sampling send
        if (tx_cnt > 0) tx_cnt--;
        else if (s_send && !stuck) tx_cnt = 10;
        if (tx_cnt == 10)     tx_state = 2'b01;
        else if (tx_cnt >= 2) tx_state = 2'b10;
        else if (tx_cnt == 1) tx_state = 2'b11;
        else                  tx_state = 2'b00;
    endtask

    task automatic clear_logs();
        send_cyc.delete(); send_gid.delete(); send_dat.delete();
        ack_cyc.delete(); err_cyc.delete();
    endtask

    task automatic wait_send(input string tag, input int bound);
        int n = 0;
        do begin step(); n++; end while (!last_send && n < bound);
        check(tag, 32'(last_send), 32'd1);
    endtask

    task automatic wait_ack(input string tag, input int bound);
        int n = 0;
        do begin step(); n++; end while (last_ack == 0 && n < bound);
        check(tag, 32'(last_ack != 0), 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n = 0;
        do begin step(); n++; end while ((busy || tx_state != 2'b00) && n < bound);
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic check_zero(input string pre);
        check({pre, "_ack"},   32'(ack),      32'd0);
        check({pre, "_send"},  32'(tx_send),  32'd0);
        check({pre, "_data"},  32'(tx_data),  32'd0);
        check({pre, "_busy"},  32'(busy),     32'd0);
        check({pre, "_grant"}, 32'(grant_id), 32'd0);
        check({pre, "_err"},   32'(err),      32'd0);
    endtask

    initial begin
        rst = 1'b1; req = '0; req_data = '0; tx_state = 2'b00;
        model_reset();
        #1 rst = 1'b0;
        #1 check_zero("rst0");
        repeat (2) step();
        #2 rst = 1'b1;

        // all four requesters held: served 0,1,2,3,0 at 14 cycles per byte
        clear_logs();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req = 4'b1111;
        begin
            int n = 0;
            while (send_cyc.size() < 5 && n < 100) begin step(); n++; end
        end
        req = 4'b0000;
        wait_idle("t2_drain", 40);
        check("t2_nsend", 32'(send_cyc.size()), 32'd5);
        check("t2_nack",  32'(ack_cyc.size()),  32'd5);
        for (int k = 0; k < 5 && k < send_cyc.size(); k++) begin
            check("t2_order", 32'(send_gid[k]), 32'(k % 4));
            check("t2_byte",  32'(send_dat[k]), 32'(8'h11 * (k % 4 + 1)));
            if (k > 0) check("t2_period", 32'(send_cyc[k] - send_cyc[k-1]), 32'd14);
        end

        // single request: one send pulse, byte A5, ack 12 cycles after send
        clear_logs();
        req_data[7:0] = 8'hA5;
        req = 4'b0001;
        wait_ack("t1_ack_seen", 40);
        req = 4'b0000;
        wait_idle("t1_drain", 20);
        check("t1_nsend", 32'(send_cyc.size()), 32'd1);
        if (send_cyc.size() == 1 && ack_cyc.size() == 1) begin
            check("t1_byte", 32'(send_dat[0]), 32'hA5);
            check("t1_lat",  32'(ack_cyc[0] - send_cyc[0]), 32'd12);
        end

        // requester 2 drops after grant: byte still sent, ack still pulsed
        clear_logs();
        req_data[23:16] = 8'h5C;
        req = 4'b0100;
        wait_send("t3_send_seen", 20);
        check("t3_gid", 32'(grant_id), 32'd2);
        repeat (3) step();
        req = 4'b0000;
        wait_ack("t3_ack_seen", 30);
        check("t3_ack", 32'(last_ack), 32'h4);
        check("t3_byte", 32'(tx_data), 32'h5C);
        wait_idle("t3_drain", 20);

        // reset mid-frame; no grant until transmitter is back to idle
        req_data[15:8] = 8'h3C;
        req = 4'b0010;
        wait_send("t4_send_seen", 20);
        repeat (5) step();
        #2 rst = 1'b0;
        #1 check_zero("t4_rst");
        repeat (2) step();
        #2 rst = 1'b1;
        clear_logs();
        wait_send("t4_regrant", 40);
        check("t4_txidle_at_grant", 32'(s_txs), 32'd0);
        check("t4_gid", 32'(grant_id), 32'd1);
        wait_ack("t4_ack_seen", 30);
        req = 4'b0000;
        wait_idle("t4_drain", 20);

        // request raised during the gap cycle
        req_data[7:0] = 8'h77;
        req = 4'b0001;
        wait_ack("t6_ack_seen", 40);
        req_data[31:24] = 8'hE1;
        req = 4'b1000;
        step();
        check("t6_gap_low", 32'(tx_send), 32'd0);
        step();
        check("t6_grant_send", 32'(tx_send), 32'd1);
        check("t6_gid", 32'(grant_id), 32'd3);
        check("t6_byte", 32'(tx_data), 32'hE1);
        wait_ack("t6_ack2_seen", 30);
        req = 4'b0000;
        wait_idle("t6_drain", 20);

        // randomized requesters against the model
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (last_ack[i] || $urandom_range(0, 63) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    req[i] = 1'b1;
                    req_data[i*8 +: 8] = 8'($urandom);
                end
            end
        end
        req = 4'b0000;
        wait_idle("rand_drain", 40);

`ifdef TX_SCHED_TIMEOUT_EN
        // transmitter never starts: abort after 4 cycles, next requester served
        clear_logs();
        stuck = 1'b1;
        req = 4'b0011;
        wait_send("to_send_seen", 20);
        begin
            int aborted = int'(grant_id);
            int n = 0;
            do begin step(); n++; end while (!last_err && n < 20);
            check("to_err_seen", 32'(last_err), 32'd1);
            if (send_cyc.size() > 0 && err_cyc.size() > 0)
                check("to_err_lat", 32'(err_cyc[0] - send_cyc[0]), 32'd5);
            check("to_no_ack", 32'(ack_cyc.size()), 32'd0);
            stuck = 1'b0;
            wait_send("to_next_send", 20);
            check("to_next_gid", 32'(grant_id), 32'(aborted ^ 1));
        end
        wait_ack("to_ack_seen", 30);
        req = 4'b0000;
        wait_idle("to_drain", 40);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
